// File: rtl/pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_pkg
// Shared definitions for the two-entry pipeline stage register:
//   - state_e       : occupancy state (EMPTY / BUSY = main only / FULL = main+skid)
//   - CTRL_* index  : bit positions inside the control-enable vector
//   - DEF_*         : default payload widths used by pipe_stage_reg
// ---------------------------------------------------------------------------
package pipe_stage_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEST_W  = 4;
    localparam int DEF_CTRL_W  = 2;

    // Control-enable bit positions
    localparam int CTRL_WB_EN    = 0;
    localparam int CTRL_MEM_R_EN = 1;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// ---------------------------------------------------------------------------
// pipe_stage_entry
// Load-enabled payload register with asynchronous active-low clear.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   async active-low clear of the stored payload
//   load_i   in   capture d_i at the next rising edge
//   d_i      in   [W-1:0] payload to capture
//   q_o      out  [W-1:0] stored payload
// ---------------------------------------------------------------------------
module pipe_stage_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Two-entry (main + skid) valid/ready pipeline stage register carrying a
// control-enable vector, two data words and a destination index.
// in_ready depends only on local state and freeze/flush, never on out_ready,
// so the ready path is registered-cut between neighbouring stages.
//
// Optional feature (macro PIPE_STAGE_STALL_CNT_EN): adds output stall_cnt,
// a saturating 16-bit count of cycles holding data without an output transfer.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   freeze                stall: no transfer on either side, hold everything
//   flush                 drop all held entries at the next edge
//   in_valid / in_ready   upstream handshake
//   in_ctrl/alu/mem/dest  incoming payload
//   out_valid / out_ready downstream handshake
//   out_ctrl/alu/mem/dest outgoing payload (out_ctrl zero when not valid)
//   stall_cnt             [15:0] stall counter (macro builds only)
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_mem,
    output logic [DEST_W-1:0] out_dest
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

    state_e             state_q, state_d;
    logic [PAY_W-1:0]   in_pay, main_pay, skid_pay, main_d;
    logic               main_load, skid_load;
    logic               in_xfer, out_xfer;
    logic [CTRL_W-1:0]  main_ctrl;

    // freeze/flush gate both handshakes, so no load can happen under them
    assign in_ready  = (state_q != ST_FULL)  && !freeze && !flush;
    assign out_valid = (state_q != ST_EMPTY) && !freeze && !flush;
    assign in_xfer   = in_valid  && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign in_pay = {in_ctrl, in_alu, in_mem, in_dest};

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_pay;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid->main move can occur
                if (out_xfer) begin
                    main_load = 1'b1;
                    main_d    = skid_pay;
                    state_d   = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush only clears occupancy; payload registers keep their contents
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_stage_entry #(.W(PAY_W)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (main_load),
        .d_i     (main_d),
        .q_o     (main_pay)
    );

    pipe_stage_entry #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (skid_load),
        .d_i     (in_pay),
        .q_o     (skid_pay)
    );

    assign {main_ctrl, out_alu, out_mem, out_dest} = main_pay;

    // A bubble must never assert write-back or memory-read enables
    assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q != ST_EMPTY) && !out_xfer && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. The reference model is a FIFO queue
// of accepted words (capacity 2); ctrl/mem/dest are derived from the alu word
// so a single queued value describes the whole expected payload.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset_n;
    logic        freeze, flush;
    logic        in_valid, in_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_alu, in_mem;
    logic [3:0]  in_dest;
    logic        out_valid, out_ready;
    logic [1:0]  out_ctrl;
    logic [31:0] out_alu, out_mem;
    logic [3:0]  out_dest;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_stage_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_alu    (in_alu),
        .in_mem    (in_mem),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_alu   (out_alu),
        .out_mem   (out_mem),
        .out_dest  (out_dest)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] mq[$];
    int          m_stall = 0;

    // Sampled outputs of the most recent cycle
    bit          s_ir, s_ov;
    logic [31:0] s_alu;

    typedef struct {
        bit          iv;
        logic [31:0] alu;
        bit          ordy;
        bit          exp_ir;
        bit          exp_ov;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [1:0] f_ctrl(input logic [31:0] a);
        return {a[0], ~a[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [31:0] a, input bit ordy,
                         input bit frz, input bit fl);
        in_valid  = iv;
        in_alu    = a;
        in_ctrl   = f_ctrl(a);
        in_mem    = ~a;
        in_dest   = a[7:4];
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
    endtask

    // One clock: apply inputs, compare against the model, advance the model.
    task automatic cyc(input bit iv, input logic [31:0] a, input bit ordy,
                       input bit frz, input bit fl);
        bit e_ir, e_ov;
        drive(iv, a, ordy, frz, fl);
        #2;
        e_ir = (mq.size() < 2) && !frz && !fl;
        e_ov = (mq.size() > 0) && !frz && !fl;
        s_ir = in_ready;
        s_ov = out_valid;
        s_alu = out_alu;
        chk("in_ready", {63'd0, in_ready}, {63'd0, e_ir});
        chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
        if (e_ov) begin
            chk("out_alu", {32'd0, out_alu}, {32'd0, mq[0]});
            chk("out_mem", {32'd0, out_mem}, {32'd0, ~mq[0]});
            chk("out_dest", {60'd0, out_dest}, {60'd0, mq[0][7:4]});
            chk("out_ctrl", {62'd0, out_ctrl}, {62'd0, f_ctrl(mq[0])});
        end else begin
            chk("bubble_ctrl", {62'd0, out_ctrl}, 64'd0);
        end
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
`endif
        if (mq.size() > 0 && !(e_ov && ordy) && m_stall < 16'hFFFF) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (e_ov && ordy) void'(mq.pop_front());
            if (e_ir && iv) mq.push_back(a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] st0;
        st0 = 16'd0;

        tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA};
        tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hB};
        tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};

        // Reset held with an input offered: nothing may appear downstream
        reset_n = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_ctrl", {62'd0, out_ctrl}, 64'd0);
            chk("rst_out_alu", {32'd0, out_alu}, 64'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("first_after_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("first_after_rst_alu", {32'd0, out_alu}, 64'hDEADBEEF);
        drain();

        // Streaming with 1-cycle lag
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            if (i > 1) chk("stream_alu", {32'd0, s_alu}, 64'(i - 1));
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_last", {32'd0, s_alu}, 64'd8);
        drain();

        // Table: fill to FULL, then drain in order
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].iv, tbl[i].alu, tbl[i].ordy, 1'b0, 1'b0);
            chk("tbl_in_ready", {63'd0, s_ir}, {63'd0, tbl[i].exp_ir});
            chk("tbl_out_valid", {63'd0, s_ov}, {63'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) chk("tbl_out_alu", {32'd0, s_alu}, {32'd0, tbl[i].exp_alu});
        end

        // Freeze in FULL for 3 cycles
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        st0 = stall_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h33, 1'b1, 1'b1, 1'b0);
            chk("frz_alu_held", {32'd0, s_alu}, 64'h11);
        end
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("frz_stall_plus3", {48'd0, stall_cnt}, {48'd0, st0 + 16'd3});
`else
        st0 = 16'd0;
`endif
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("frz_order0", {32'd0, s_alu}, 64'h11);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("frz_order1", {32'd0, s_alu}, 64'h22);
        drain();

        // Flush with freeze and input in FULL
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h66, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_empty", {63'd0, s_ov}, 64'd0);
        chk("flush_data_kept", {32'd0, s_alu}, 64'h44);
        cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("flush_drop_input", {32'd0, s_alu}, 64'h77);
        drain();

        // Asynchronous reset in the middle of a cycle while FULL
        cyc(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_alu", {32'd0, out_alu}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        mq.delete();
        m_stall = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 32'hAB, 1'b1, 1'b0, 1'b0);
        chk("arst_accept_empty", {63'd0, s_ov}, 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("arst_first_out", {32'd0, s_alu}, 64'hAB);
        drain();

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        drain();

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Long stall: counter must saturate, not wrap
        cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        chk("stall_saturate", {48'd0, stall_cnt}, 64'hFFFF);
        chk("stall_busy_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_busy_alu", {32'd0, out_alu}, 64'h5);
        m_stall = 16'hFFFF;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each of the two data payload fields.
REQ-002 SHALL have parameter DEST_W, default 4, destination register index width.
REQ-003 SHALL have parameter CTRL_W, default 2, control-enable bit vector width (bit0 WB_en, bit1 MEM_R_en).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port freeze  input  1  memory-stall hold; no transfer on either side while high.
REQ-007 SHALL have port flush  input  1  discard all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-010 SHALL have ports in_ctrl / in_alu / in_mem / in_dest  input  CTRL_W / DATA_W / DATA_W / DEST_W  incoming payload.
REQ-011 SHALL have port out_valid  output  1  held entry presented downstream.
REQ-012 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-013 SHALL have ports out_ctrl / out_alu / out_mem / out_dest  output  CTRL_W / DATA_W / DATA_W / DEST_W  outgoing payload.
REQ-014 SHALL have port stall_cnt  output  16  stall cycle count (present only per REQ-031).

Function
REQ-015 SHALL hold up to two entries, main and skid, with states EMPTY, BUSY (main only), FULL (main + skid).
REQ-016 SHALL define input transfer as in_valid && in_ready and output transfer as out_valid && out_ready.
REQ-017 SHALL drive in_ready = (state != FULL) && !freeze && !flush, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY) && !freeze && !flush, and out_* from main.
REQ-019 SHALL force out_ctrl to all-zero whenever out_valid is 0, so that a bubble asserts no enables.
REQ-020 SHALL transition EMPTY->BUSY on input transfer, with 1-cycle latency from in_valid to out_valid.
REQ-021 SHALL, in BUSY, load main on simultaneous input+output transfer (stay BUSY), go to FULL with the entry loaded into skid on input transfer only, and go to EMPTY on output transfer only.
REQ-022 SHALL, in FULL, move skid to main on output transfer and go to BUSY, and otherwise hold.
REQ-023 SHALL sustain one transfer per cycle in steady state, with no entry lost or duplicated.
REQ-024 SHALL, while freeze=1, hold state and all payload registers unchanged.
REQ-025 SHALL, on flush=1, go to EMPTY at the next edge, with priority over freeze and any transfer; a concurrent input is dropped.
REQ-026 SHALL leave payload data registers untouched by flush, with only validity cleared.

Reset
REQ-027 SHALL, while reset_n=0 and independent of clk, set state EMPTY, clear all payload and ctrl registers to 0, and clear stall_cnt to 0.
REQ-028 SHALL, when reset is asserted mid-operation, discard all held entries; the first accept after release is into EMPTY.

Configuration
REQ-029 SHALL provide macro PIPE_STAGE_STALL_CNT_EN.
REQ-030 SHALL, when PIPE_STAGE_STALL_CNT_EN is defined, increment stall_cnt every cycle where state != EMPTY and no output transfer occurs, including freeze cycles, saturating at 0xFFFF.
REQ-031 SHALL, when PIPE_STAGE_STALL_CNT_EN is undefined, omit the stall_cnt port and counter, with all other behaviour identical.

Structure
REQ-032 SHALL place the state enum (EMPTY/BUSY/FULL), the CTRL bit index constants and the default widths in shared package pipe_stage_pkg.
REQ-033 SHALL implement main and skid as two instances of sub-module pipe_stage_entry, a load-enabled payload register with async active-low clear.

Verification
REQ-034 SHALL verify: reset_n=0 with in_valid=1, in_alu=0xDEADBEEF -> out_valid=0, out_ctrl=0, out_alu=0 until one edge after release.
REQ-035 SHALL verify: out_ready=1 and in_valid=1 for 8 cycles carrying in_alu=1..8 -> out_alu=1..8 on consecutive cycles, 1-cycle lag.
REQ-036 SHALL verify: with out_ready=0, push in_alu=0xA then 0xB -> state FULL, in_ready=0; set out_ready=1 -> 0xA then 0xB emitted, back to EMPTY.
REQ-037 SHALL verify: freeze=1 for 3 cycles in FULL -> out_valid=0, in_ready=0, payloads unchanged, stall_cnt +3; drop freeze -> order preserved.
REQ-038 SHALL verify: flush=1 together with freeze=1 and in_valid=1 in FULL -> next cycle EMPTY, out_ctrl=0, input not accepted.
REQ-039 SHALL verify: with PIPE_STAGE_STALL_CNT_EN defined, hold BUSY with out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF and no wrap.
